// File: rtl/lsq_param.sv
// lsq_param: in-order load/store queue with CDB operand snooping and one outstanding memory request.
// Optional misaligned-access trap is enabled by defining LSQ_MISALIGN_CHK_EN.
module lsq_param #(
    parameter int DEPTH   = 8,
    parameter int ROB_W   = 4,
    parameter int NUM_CDB = 2
) (
    input  logic                       clk_in,
    input  logic                       rst_n_in,
    input  logic                       rdy_in,
    input  logic                       clr_in,
    input  logic                       issue_valid,
    input  logic [ROB_W-1:0]           issue_rob_index,
    input  logic                       issue_is_store,
    input  logic [1:0]                 issue_size,
    input  logic                       issue_unsigned,
    input  logic [31:0]                issue_rs1_val,
    input  logic [31:0]                issue_rs2_val,
    input  logic [31:0]                issue_imm,
    input  logic [ROB_W-1:0]           issue_rs1_depend,
    input  logic [ROB_W-1:0]           issue_rs2_depend,
    input  logic [NUM_CDB-1:0]         cdb_valid,
    input  logic [NUM_CDB*ROB_W-1:0]   cdb_rob_index,
    input  logic [NUM_CDB*32-1:0]      cdb_result,
    input  logic                       commit_valid,
    input  logic [ROB_W-1:0]           commit_rob_index,
    output logic                       mem_req_valid,
    output logic                       mem_req_write,
    output logic [2:0]                 mem_req_len,
    output logic [31:0]                mem_req_addr,
    output logic [31:0]                mem_req_data,
    input  logic                       mem_done,
    input  logic [31:0]                mem_rdata,
    output logic                       lsq_full,
    output logic [$clog2(DEPTH+1)-1:0] lsq_count,
    output logic                       out_valid,
    output logic [ROB_W-1:0]           out_rob_index,
    output logic [31:0]                out_result,
    output logic                       out_misalign
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DRAIN} state_t;

    typedef struct packed {
        logic             valid;
        logic [ROB_W-1:0] rob;
        logic             store;
        logic [1:0]       size;
        logic             uns;
        logic [31:0]      rs1;
        logic [31:0]      rs2;
        logic [31:0]      imm;
        logic [ROB_W-1:0] dep1;
        logic [ROB_W-1:0] dep2;
    } entry_t;

    state_t           r_state, w_state_next;
    logic [PTR_W-1:0] r_head, r_tail;
    logic [CNT_W-1:0] r_count;
    logic             r_kill;
    logic             r_req_write;
    logic [2:0]       r_req_len;
    logic [31:0]      r_req_addr, r_req_data;
    logic [ROB_W-1:0] r_req_rob;
    logic [1:0]       r_req_size;
    logic             r_req_uns;
    logic             r_out_valid, r_out_mis;
    logic [ROB_W-1:0] r_out_rob;
    logic [31:0]      r_out_result;

    entry_t      w_ent [DEPTH];
    entry_t      w_head, w_new_ent;
    logic [32:0] w_iss_s1, w_iss_s2;
    logic [31:0] w_addr, w_load_ext;
    logic        w_enq, w_head_ready, w_dispatch, w_mis, w_complete;

    // {hit, value}: CDB buses beat our own broadcast, and the lowest bus index wins.
    function automatic logic [32:0] snoop(input logic [ROB_W-1:0] tag);
        logic [32:0] res;
        res = '0;
        if (r_out_valid && r_out_rob == tag)
            res = {1'b1, r_out_result};
        for (int k = NUM_CDB-1; k >= 0; k--)
            if (cdb_valid[k] && cdb_rob_index[k*ROB_W +: ROB_W] == tag)
                res = {1'b1, cdb_result[k*32 +: 32]};
        if (tag == '0)
            res = '0;
        return res;
    endfunction

    always_comb begin
        w_iss_s1        = snoop(issue_rs1_depend);
        w_iss_s2        = snoop(issue_rs2_depend);
        w_new_ent.valid = 1'b1;
        w_new_ent.rob   = issue_rob_index;
        w_new_ent.store = issue_is_store;
        w_new_ent.size  = issue_size;
        w_new_ent.uns   = issue_unsigned;
        w_new_ent.imm   = issue_imm;
        w_new_ent.rs1   = w_iss_s1[32] ? w_iss_s1[31:0] : issue_rs1_val;
        w_new_ent.dep1  = w_iss_s1[32] ? '0 : issue_rs1_depend;
        w_new_ent.rs2   = w_iss_s2[32] ? w_iss_s2[31:0] : issue_rs2_val;
        w_new_ent.dep2  = w_iss_s2[32] ? '0 : issue_rs2_depend;
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_ent
            entry_t      r_ent;
            logic [32:0] w_s1, w_s2;
            assign w_s1      = snoop(r_ent.dep1);
            assign w_s2      = snoop(r_ent.dep2);
            assign w_ent[gi] = r_ent;

            always_ff @(posedge clk_in or negedge rst_n_in) begin
                if (!rst_n_in) begin
                    r_ent <= '0;
                end else if (rdy_in) begin
                    if (clr_in) begin
                        r_ent.valid <= 1'b0;
                    end else if (w_enq && r_tail == PTR_W'(gi)) begin
                        r_ent <= w_new_ent;
                    end else begin
                        if (w_dispatch && r_head == PTR_W'(gi))
                            r_ent.valid <= 1'b0;
                        if (w_s1[32]) begin
                            r_ent.rs1  <= w_s1[31:0];
                            r_ent.dep1 <= '0;
                        end
                        if (w_s2[32]) begin
                            r_ent.rs2  <= w_s2[31:0];
                            r_ent.dep2 <= '0;
                        end
                    end
                end
            end
        end
    endgenerate

    assign w_head       = w_ent[r_head];
    assign w_addr       = w_head.rs1 + w_head.imm;
    assign w_enq        = issue_valid && !lsq_full && !clr_in;
    assign w_head_ready = w_head.valid && w_head.dep1 == '0 && w_head.dep2 == '0 &&
                          (!w_head.store || (commit_valid && commit_rob_index == w_head.rob));
    assign w_dispatch   = (r_state == S_IDLE) && w_head_ready && !clr_in;
    // A flush races the completion: results of flushed or killed ops are never broadcast.
    assign w_complete   = (r_state == S_BUSY) && mem_done && !r_kill && !clr_in;
`ifdef LSQ_MISALIGN_CHK_EN
    assign w_mis = (w_head.size == 2'd1 && w_addr[0]) || (w_head.size[1] && w_addr[1:0] != 2'b00);
`else
    assign w_mis = 1'b0;
`endif

    always_comb begin
        w_load_ext = mem_rdata;
        case (r_req_size)
            2'd0:    w_load_ext = r_req_uns ? {24'd0, mem_rdata[7:0]} : {{24{mem_rdata[7]}}, mem_rdata[7:0]};
            2'd1:    w_load_ext = r_req_uns ? {16'd0, mem_rdata[15:0]} : {{16{mem_rdata[15]}}, mem_rdata[15:0]};
            default: w_load_ext = mem_rdata;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_dispatch && !w_mis) w_state_next = S_BUSY;
            S_BUSY:  if (mem_done) w_state_next = S_IDLE;
                     else if (clr_in && !r_req_write) w_state_next = S_DRAIN;
            S_DRAIN: if (mem_done) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in)   r_state <= S_IDLE;
        else if (rdy_in) r_state <= w_state_next;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_head <= '0;  r_tail <= '0;  r_count <= '0;  r_kill <= 1'b0;
            r_req_write <= 1'b0;  r_req_len <= '0;  r_req_addr <= '0;  r_req_data <= '0;
            r_req_rob <= '0;  r_req_size <= '0;  r_req_uns <= 1'b0;
            r_out_valid <= 1'b0;  r_out_mis <= 1'b0;  r_out_rob <= '0;  r_out_result <= '0;
        end else if (rdy_in) begin
            if (clr_in) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_enq)      r_tail <= r_tail + PTR_W'(1);
                if (w_dispatch) r_head <= r_head + PTR_W'(1);
                r_count <= r_count + CNT_W'(w_enq) - CNT_W'(w_dispatch);
            end
            if (w_dispatch)
                r_kill <= 1'b0;
            else if (r_state == S_BUSY && clr_in)
                r_kill <= 1'b1;
            if (w_dispatch) begin
                r_req_write <= w_head.store;
                r_req_len   <= (w_head.size == 2'd0) ? 3'd1 : (w_head.size == 2'd1) ? 3'd2 : 3'd4;
                r_req_addr  <= w_addr;
                r_req_data  <= w_head.rs2;
                r_req_rob   <= w_head.rob;
                r_req_size  <= w_head.size;
                r_req_uns   <= w_head.uns;
            end
            r_out_valid <= 1'b0;
            r_out_mis   <= 1'b0;
            if (w_complete) begin
                r_out_valid  <= 1'b1;
                r_out_rob    <= r_req_rob;
                r_out_result <= r_req_write ? 32'd0 : w_load_ext;
            end else if (w_dispatch && w_mis) begin
                r_out_valid  <= 1'b1;
                r_out_mis    <= 1'b1;
                r_out_rob    <= w_head.rob;
                r_out_result <= 32'd0;
            end
        end
    end

    assign mem_req_valid = (r_state != S_IDLE);
    assign mem_req_write = r_req_write;
    assign mem_req_len   = r_req_len;
    assign mem_req_addr  = r_req_addr;
    assign mem_req_data  = r_req_data;
    assign lsq_full      = (r_count == CNT_W'(DEPTH));
    assign lsq_count     = r_count;
    assign out_valid     = r_out_valid;
    assign out_rob_index = r_out_rob;
    assign out_result    = r_out_result;
    assign out_misalign  = r_out_mis;
endmodule

// File: tb/tb_lsq_param.sv
// Scoreboard bench for lsq_param (DEPTH=4): expected requests and completions are queued at issue
// time and retired by a memory responder and an output monitor.
`timescale 1ns/1ps
module tb_lsq_param;
    localparam int DEPTH = 4, ROB_W = 4, NUM_CDB = 2;
    localparam int CNT_W = $clog2(DEPTH+1);

    logic clk_in = 1'b0, rst_n_in = 1'b0, rdy_in = 1'b1, clr_in = 1'b0;
    logic issue_valid = 1'b0, issue_is_store = 1'b0, issue_unsigned = 1'b0;
    logic [ROB_W-1:0] issue_rob_index = '0, issue_rs1_depend = '0, issue_rs2_depend = '0;
    logic [1:0] issue_size = '0;
    logic [31:0] issue_rs1_val = '0, issue_rs2_val = '0, issue_imm = '0;
    logic [NUM_CDB-1:0] cdb_valid = '0;
    logic [NUM_CDB*ROB_W-1:0] cdb_rob_index = '0;
    logic [NUM_CDB*32-1:0] cdb_result = '0;
    logic commit_valid = 1'b0;
    logic [ROB_W-1:0] commit_rob_index = '0;
    logic mem_req_valid, mem_req_write, mem_done, lsq_full, out_valid, out_misalign;
    logic [2:0] mem_req_len;
    logic [31:0] mem_req_addr, mem_req_data, mem_rdata, out_result;
    logic [CNT_W-1:0] lsq_count;
    logic [ROB_W-1:0] out_rob_index;

    always #5 clk_in = ~clk_in;

    lsq_param #(.DEPTH(DEPTH), .ROB_W(ROB_W), .NUM_CDB(NUM_CDB)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .clr_in(clr_in),
        .issue_valid(issue_valid), .issue_rob_index(issue_rob_index), .issue_is_store(issue_is_store),
        .issue_size(issue_size), .issue_unsigned(issue_unsigned), .issue_rs1_val(issue_rs1_val),
        .issue_rs2_val(issue_rs2_val), .issue_imm(issue_imm), .issue_rs1_depend(issue_rs1_depend),
        .issue_rs2_depend(issue_rs2_depend), .cdb_valid(cdb_valid), .cdb_rob_index(cdb_rob_index),
        .cdb_result(cdb_result), .commit_valid(commit_valid), .commit_rob_index(commit_rob_index),
        .mem_req_valid(mem_req_valid), .mem_req_write(mem_req_write), .mem_req_len(mem_req_len),
        .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_done(mem_done),
        .mem_rdata(mem_rdata), .lsq_full(lsq_full), .lsq_count(lsq_count), .out_valid(out_valid),
        .out_rob_index(out_rob_index), .out_result(out_result), .out_misalign(out_misalign)
    );

    typedef struct { logic write; logic [2:0] len; logic [31:0] addr; logic [31:0] data; } req_t;
    typedef struct { logic [ROB_W-1:0] rob; logic [31:0] result; logic mis; } out_t;
    req_t exp_req[$];
    out_t exp_out[$];
    req_t req_e;
    out_t out_e;
    int total = 0, bad = 0;
    int mem_lat = 2;
    logic [31:0] rdata_val = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic push_req(input logic w, input logic [2:0] len, input logic [31:0] a, input logic [31:0] d);
        req_t r;
        r.write = w; r.len = len; r.addr = a; r.data = d;
        exp_req.push_back(r);
    endtask

    task automatic push_out(input logic [ROB_W-1:0] rob, input logic [31:0] res, input logic mis);
        out_t o;
        o.rob = rob; o.result = res; o.mis = mis;
        exp_out.push_back(o);
    endtask

    task automatic issue(input logic [ROB_W-1:0] rob, input logic st, input logic [1:0] sz, input logic uns,
                         input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                         input logic [ROB_W-1:0] d1, input logic [ROB_W-1:0] d2);
        issue_valid = 1'b1; issue_rob_index = rob; issue_is_store = st; issue_size = sz;
        issue_unsigned = uns; issue_rs1_val = rs1; issue_rs2_val = rs2; issue_imm = imm;
        issue_rs1_depend = d1; issue_rs2_depend = d2;
        tick();
        issue_valid = 1'b0; issue_rs1_depend = '0; issue_rs2_depend = '0;
    endtask

    task automatic set_cdb(input logic [1:0] v, input logic [3:0] t0, input logic [31:0] r0,
                           input logic [3:0] t1, input logic [31:0] r1);
        cdb_valid = v;
        cdb_rob_index[0 +: ROB_W] = t0; cdb_result[0 +: 32] = r0;
        cdb_rob_index[ROB_W +: ROB_W] = t1; cdb_result[32 +: 32] = r1;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while ((exp_req.size() != 0 || exp_out.size() != 0 || mem_req_valid) && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 32'(n < budget), 32'd1);
        tick();
    endtask

    task automatic wait_req(input string tag, input int budget);
        int n;
        n = 0;
        while (!mem_req_valid && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 32'(mem_req_valid), 32'd1);
    endtask

    // Memory model: checks each new request, answers mem_lat cycles later with a one-cycle mem_done.
    initial begin
        mem_done = 1'b0;
        mem_rdata = '0;
        forever begin
            tick();
            if (rst_n_in && mem_req_valid) begin
                $display("req wr=%0d len=%0d addr=%08h data=%08h", mem_req_write, mem_req_len, mem_req_addr, mem_req_data);
                if (exp_req.size() == 0) begin
                    chk("unexpected_req", 32'(mem_req_valid), 32'd0);
                end else begin
                    req_e = exp_req.pop_front();
                    chk("req_write", 32'(mem_req_write), 32'(req_e.write));
                    chk("req_len", 32'(mem_req_len), 32'(req_e.len));
                    chk("req_addr", mem_req_addr, req_e.addr);
                    chk("req_data", mem_req_data, req_e.data);
                end
                repeat (mem_lat) @(posedge clk_in);
                #1;
                mem_done = 1'b1;
                mem_rdata = rdata_val;
                tick();
                mem_done = 1'b0;
            end
        end
    end

    always @(negedge clk_in) begin
        if (rst_n_in && out_valid) begin
            $display("out rob=%0d result=%08h mis=%0d", out_rob_index, out_result, out_misalign);
            if (exp_out.size() == 0) begin
                chk("unexpected_out", 32'(out_valid), 32'd0);
            end else begin
                out_e = exp_out.pop_front();
                chk("out_rob", 32'(out_rob_index), 32'(out_e.rob));
                chk("out_result", out_result, out_e.result);
                chk("out_misalign", 32'(out_misalign), 32'(out_e.mis));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        chk("rst_req_valid", 32'(mem_req_valid), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_count", 32'(lsq_count), 0);
        chk("rst_full", 32'(lsq_full), 0);
        chk("rst_addr", mem_req_addr, 0);
        chk("rst_result", out_result, 0);
        rst_n_in = 1'b1;
        tick();

        // Loads of every size, signed and unsigned.
        rdata_val = 32'h0000_00F0;
        push_req(0, 1, 32'h103, 0); push_out(1, 32'hFFFF_FFF0, 0);
        issue(1, 0, 0, 0, 32'h100, 0, 3, 0, 0);
        wait_idle("lb_done", 40);
        push_req(0, 1, 32'h103, 0); push_out(2, 32'h0000_00F0, 0);
        issue(2, 0, 0, 1, 32'h100, 0, 3, 0, 0);
        wait_idle("lbu_done", 40);
        rdata_val = 32'h0000_8001;
        push_req(0, 2, 32'h202, 0); push_out(3, 32'hFFFF_8001, 0);
        issue(3, 0, 1, 0, 32'h200, 0, 2, 0, 0);
        wait_idle("lh_done", 40);
        rdata_val = 32'h1234_5678;
        push_req(0, 4, 32'h304, 0); push_out(4, 32'h1234_5678, 0);
        issue(4, 0, 2, 0, 32'h300, 0, 4, 0, 0);
        wait_idle("lw_done", 40);

        // Store whose data arrives on CDB bus 1 in the issue cycle; waits for commit.
        set_cdb(2'b11, 4'd7, 32'h1111_1111, 4'd5, 32'hDEAD_BEEF);
        issue(6, 1, 2, 0, 32'h400, 32'h0, 8, 0, 5);
        set_cdb(2'b00, 0, 0, 0, 0);
        repeat (3) tick();
        chk("st_wait_commit", 32'(mem_req_valid), 0);
        chk("st_count", 32'(lsq_count), 1);
        push_req(1, 4, 32'h408, 32'hDEAD_BEEF); push_out(6, 0, 0);
        commit_valid = 1'b1; commit_rob_index = 6;
        tick();
        commit_valid = 1'b0;
        wait_idle("sw_done", 40);

        // Same tag on both buses: bus 0 wins.
        rdata_val = 32'h0000_0055;
        set_cdb(2'b11, 4'd3, 32'h500, 4'd3, 32'h600);
        push_req(0, 4, 32'h500, 0); push_out(7, 32'h55, 0);
        issue(7, 0, 2, 0, 32'h0, 0, 0, 3, 0);
        set_cdb(2'b00, 0, 0, 0, 0);
        wait_idle("prio_done", 40);

        // Fill the queue, drop a fifth issue, then resolve via CDB and via our own broadcast.
        rdata_val = 32'h0000_0080;
        push_req(0, 1, 32'h1010, 0);     push_out(1, 32'hFFFF_FF80, 0);
        push_req(0, 2, 32'h2002, 0);     push_out(2, 32'h0000_0080, 0);
        push_req(0, 4, 32'h3000, 0);     push_out(3, 32'h0000_0080, 0);
        push_req(0, 1, 32'hFFFF_FF84, 0); push_out(4, 32'h0000_0080, 0);
        issue(1, 0, 0, 0, 0, 0, 32'h10, 9, 0);
        issue(2, 0, 1, 1, 0, 0, 32'h2, 10, 0);
        issue(3, 0, 2, 0, 0, 0, 32'h0, 11, 0);
        issue(4, 0, 0, 1, 0, 0, 32'h4, 1, 0);
        chk("full_count", 32'(lsq_count), 4);
        chk("full_flag", 32'(lsq_full), 1);
        issue(13, 0, 2, 0, 32'h40, 0, 0, 0, 0);
        chk("full_drop_count", 32'(lsq_count), 4);
        set_cdb(2'b11, 4'd9, 32'h1000, 4'd10, 32'h2000);
        tick();
        set_cdb(2'b01, 4'd11, 32'h3000, 4'd0, 0);
        tick();
        set_cdb(2'b00, 0, 0, 0, 0);
        wait_idle("full_drain", 120);
        chk("full_empty_count", 32'(lsq_count), 0);
        chk("full_empty_flag", 32'(lsq_full), 0);

        // Flush while a load is in flight: DRAIN, no broadcast, queued entry discarded.
        mem_lat = 4;
        rdata_val = 32'h0000_1234;
        push_req(0, 4, 32'h600, 0);
        issue(5, 0, 2, 0, 32'h600, 0, 0, 0, 0);
        wait_req("clr_ld_req", 20);
        issue(6, 0, 2, 0, 32'h650, 0, 0, 14, 0);
        chk("clr_pre_count", 32'(lsq_count), 1);
        clr_in = 1'b1;
        tick();
        clr_in = 1'b0;
        chk("clr_count", 32'(lsq_count), 0);
        chk("drain_holds_req", 32'(mem_req_valid), 1);
        push_req(0, 4, 32'h700, 0); push_out(7, 32'h0000_1234, 0);
        issue(7, 0, 2, 0, 32'h700, 0, 0, 0, 0);
        set_cdb(2'b01, 4'd14, 32'h0, 4'd0, 0);
        tick();
        set_cdb(2'b00, 0, 0, 0, 0);
        wait_idle("clr_ld_done", 60);

        // Flush while a store is in flight: it completes silently.
        mem_lat = 3;
        push_req(1, 4, 32'h800, 32'hCAFE_F00D);
        issue(8, 1, 2, 0, 32'h800, 32'hCAFE_F00D, 0, 0, 0);
        commit_valid = 1'b1; commit_rob_index = 8;
        tick();
        commit_valid = 1'b0;
        wait_req("clr_st_req", 20);
        clr_in = 1'b1;
        tick();
        clr_in = 1'b0;
        chk("clr_st_busy", 32'(mem_req_valid), 1);
        wait_idle("clr_st_done", 60);

        // Misaligned word access.
        mem_lat = 2;
        rdata_val = 32'h0BAD_F00D;
`ifdef LSQ_MISALIGN_CHK_EN
        push_out(9, 0, 1);
        issue(9, 0, 2, 0, 32'h100, 0, 2, 0, 0);
        for (int i = 0; i < 4; i++) begin
            chk("mis_no_req", 32'(mem_req_valid), 0);
            tick();
        end
`else
        push_req(0, 4, 32'h102, 0); push_out(9, 32'h0BAD_F00D, 0);
        issue(9, 0, 2, 0, 32'h100, 0, 2, 0, 0);
`endif
        wait_idle("mis_done", 40);

        // Asynchronous reset while BUSY.
        mem_lat = 6;
        push_req(0, 4, 32'h900, 0);
        issue(10, 0, 2, 0, 32'h900, 0, 0, 0, 0);
        wait_req("rst_busy_req", 20);
        issue(11, 0, 2, 0, 32'h910, 0, 0, 15, 0);
        #2;
        rst_n_in = 1'b0;
        #1;
        chk("arst_req_valid", 32'(mem_req_valid), 0);
        chk("arst_out_valid", 32'(out_valid), 0);
        chk("arst_count", 32'(lsq_count), 0);
        repeat (2) tick();
        rst_n_in = 1'b1;
        repeat (10) tick();

        mem_lat = 2;
        rdata_val = 32'h0000_007F;
        push_req(0, 1, 32'h41, 0); push_out(12, 32'h7F, 0);
        issue(12, 0, 0, 0, 32'h40, 0, 1, 0, 0);
        wait_idle("post_rst_done", 40);

        chk("sb_req_left", 32'(exp_req.size()), 0);
        chk("sb_out_left", 32'(exp_out.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lsq_param.md
# lsq_param

Parametrised load/store queue: successor to the fixed-size load/store buffer in the out-of-order RISC-V core. Sits between issue, the ROB and the memory controller. Holds up to DEPTH memory ops in program order and snoops NUM_CDB result buses plus its own output for operand wakeup. Loads execute at the queue head without waiting for commit; stores wait for ROB commit. Flushes mid-transaction without corrupting memory.

## Interface
- DEPTH, 8: queue entries; power of two, ≥2.
- ROB_W, 4: ROB index width; index 0 means "no dependency".
- NUM_CDB, 2: external wakeup buses.
- clk_in  in  1  clock.
- rst_n_in  in  1  reset, asynchronous, active-low.
- rdy_in  in  1  global stall when low; all state holds.
- clr_in  in  1  misprediction flush, synchronous.
- issue_valid  in  1  enqueue request; ignored when lsq_full.
- issue_rob_index  in  ROB_W  destination ROB entry.
- issue_is_store  in  1  1 = store.
- issue_size  in  2  0 = byte, 1 = half, 2 = word.
- issue_unsigned  in  1  zero-extend load (LBU/LHU).
- issue_rs1_val, issue_rs2_val, issue_imm  in  32 each  operand values / offset.
- issue_rs1_depend, issue_rs2_depend  in  ROB_W each  producer tags.
- cdb_valid  in  NUM_CDB  per-bus valid.
- cdb_rob_index  in  NUM_CDB*ROB_W  bus k at [k*ROB_W +: ROB_W].
- cdb_result  in  NUM_CDB*32  bus k at [k*32 +: 32].
- commit_valid, commit_rob_index  in  1, ROB_W  ROB head commit.
- mem_req_valid  out  1  request held until mem_done.
- mem_req_write  out  1  store.
- mem_req_len  out  3  bytes: 1, 2 or 4.
- mem_req_addr, mem_req_data  out  32 each.
- mem_done, mem_rdata  in  1, 32  one-cycle completion, load data.
- lsq_full  out  1  count == DEPTH.
- lsq_count  out  $clog2(DEPTH+1)  occupancy.
- out_valid, out_rob_index, out_result  out  1, ROB_W, 32  completion broadcast.
- out_misalign  out  1  only with LSQ_MISALIGN_CHK_EN.

## Operation
- Circular buffer: head and tail pointers of $clog2(DEPTH) bits plus count; all DEPTH slots usable; wrap at DEPTH-1 → 0.
- Enqueue at tail when issue_valid && !lsq_full. Same-cycle dequeue and enqueue when full is not allowed; lsq_full is registered occupancy.
- Wakeup: for every valid entry and for the incoming issue operand, a tag equal to a valid cdb bus or to out_rob_index (when out_valid) takes the value and clears the tag. The lowest bus index wins on duplicate tags. Tag 0 never matches.
- FSM IDLE/BUSY/DRAIN.
- IDLE → BUSY when the head is valid, both tags are 0, and the op is a load, or a store with commit_valid && commit_rob_index == the head index. The head pops and request registers load.
- Address = rs1 + imm, mod 2^32. Data = rs2.
- BUSY → IDLE on mem_done. Register out_valid for one cycle.
  - Load result: sign-extend per size, or zero-extend if unsigned.
  - Store result: 0.
- clr_in empties the queue and clears count.
  - In IDLE: stays IDLE.
  - In BUSY with a store: stays BUSY; completes with no out_valid.
  - In BUSY with a load: goes to DRAIN. DRAIN holds the request until mem_done, then goes to IDLE with no out_valid.
- mem_done outside BUSY/DRAIN is ignored.
- Reset values: all outputs 0, FSM IDLE, pointers and count 0, entry valids 0.

## Timing
- Enqueue at edge t: entry eligible for dispatch evaluation at t+1.
- Dispatch decision at cycle t: mem_req_valid high from t+1.
- mem_done at t: out_valid at t+1, FSM IDLE at t+1. Earliest next mem_req_valid at t+2.
- out_valid is a single-cycle pulse. out_result and out_rob_index hold until the next completion.
- rdy_in low freezes everything, including snooping. mem_req_* remain stable.

## Configuration
- LSQ_MISALIGN_CHK_EN defined: at dispatch, half with addr[0]≠0 or word with addr[1:0]≠0 issues no memory request. The entry pops, and the next cycle gives out_valid=1, out_misalign=1, out_result=0.
- Undefined: no check; address passed unchanged; out_misalign tied 0.

## Test plan
- Reset mid-BUSY (rst_n_in low asynchronously) → mem_req_valid, out_valid drop immediately; count 0.
- LB with rs1=0x100, imm=3, mem_rdata=0x000000F0 → mem_req_len=1, addr 0x103, out_result=0xFFFFFFF0. Same with LBU → 0x000000F0.
- SW, rs2 tag 5, cdb bus 1 broadcasts tag 5 value 0xDEADBEEF same cycle as issue; commit tag matches → mem_req_data=0xDEADBEEF, mem_req_write=1.
- DEPTH=4: enqueue 4 ops with unresolved tags → lsq_full=1, 5th issue dropped. Resolve all → 4 completions in order; pointers wrap.
- Load in BUSY, clr_in pulse, mem_done 3 cycles later → no out_valid; FSM IDLE after mem_done; a new load issued after clr dispatches afterwards.
- LSQ_MISALIGN_CHK_EN: LW addr 0x102 → no mem_req_valid, out_misalign=1 one cycle.
